// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder: NSEG segments of NBIT/NSEG bits, one segment summed per stage, GW-bit lookahead groups.
// Latency NSEG cycles accept-to-out_valid, one result per clock; define CLA_SUB_EN to enable a-b via the sub port.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready = !out_valid || out_ready.
module cla_adder_pipe #(
    parameter int NBIT = 1024,
    parameter int NSEG = 8,
    parameter int GW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] s,
    output logic            cout
);
    localparam int SEGW = NBIT / NSEG;
    localparam int NGRP = SEGW / GW;

    logic            adv;
    logic [NBIT-1:0] b_eff;
    logic            cin_eff;

`ifdef CLA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = cin;
`endif

    // One segment: bit carries from in-group prefix G/P, group carries chained across groups.
    function automatic logic [SEGW:0] seg_add(input logic [SEGW-1:0] x,
                                              input logic [SEGW-1:0] y,
                                              input logic            ci);
        logic [SEGW-1:0] g;
        logic [SEGW-1:0] p;
        logic [SEGW-1:0] sm;
        logic [NGRP:0]   gc;
        logic            gg;
        logic            gp;
        logic            bc;
        g     = x & y;
        p     = x ^ y;
        sm    = '0;
        gc    = '0;
        gc[0] = ci;
        for (int j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < GW; i++) begin
                bc              = gg | (gp & gc[j]);
                sm[j*GW + i]    = p[j*GW + i] ^ bc;
                gg              = g[j*GW + i] | (p[j*GW + i] & gg);
                gp              = gp & p[j*GW + i];
            end
            gc[j+1] = gg | (gp & gc[j]);
        end
        return {gc[NGRP], sm};
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int LOW = k * SEGW;

        logic                vld_q;
        logic                vld_d;
        logic                cy_q;
        logic                cy_d;
        logic [LOW+SEGW-1:0] sum_q;
        logic [LOW+SEGW-1:0] sum_d;
        logic [NBIT-LOW-1:0] src_a;
        logic [NBIT-LOW-1:0] src_b;
        logic                src_c;
        logic [SEGW:0]       res;

        if (k == 0) begin : g_first
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = cin_eff;
            assign vld_d = in_valid;
            assign sum_d = res[SEGW-1:0];
        end else begin : g_next
            assign src_a = g_stg[k-1].g_skew.a_q;
            assign src_b = g_stg[k-1].g_skew.b_q;
            assign src_c = g_stg[k-1].cy_q;
            assign vld_d = g_stg[k-1].vld_q;
            // Lower sum segments ride along so the full sum lands aligned at the last stage.
            assign sum_d = {res[SEGW-1:0], g_stg[k-1].sum_q};
        end

        assign res  = seg_add(src_a[SEGW-1:0], src_b[SEGW-1:0], src_c);
        assign cy_d = res[SEGW];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                sum_q <= sum_d;
            end
        end

        if (k < NSEG - 1) begin : g_skew
            logic [NBIT-LOW-SEGW-1:0] a_q;
            logic [NBIT-LOW-SEGW-1:0] b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= src_a[NBIT-LOW-1:SEGW];
                    b_q <= src_b[NBIT-LOW-1:SEGW];
                end
            end
        end
    end

    assign out_valid = g_stg[NSEG-1].vld_q;
    assign s         = g_stg[NSEG-1].sum_q;
    assign cout      = g_stg[NSEG-1].cy_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: a 16-bit/4-stage instance for directed and stall tests, a default 1024-bit instance for a random stream.
module tb_cla_adder_pipe;
    localparam int W  = 16;
    localparam int WW = 1024;
`ifdef CLA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0]  a, b, s;
    logic          w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout;
    logic [WW-1:0] w_a, w_b, w_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    cla_adder_pipe #(.NBIT(W), .NSEG(4), .GW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
    );

    cla_adder_pipe dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .s(w_s), .cout(w_cout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model16(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic sb);
        if (sb && SUB_EN) return {1'b0, x} + {1'b0, ~y} + 17'd1;
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    function automatic logic [WW:0] model_w(input logic [WW-1:0] x, input logic [WW-1:0] y,
                                            input logic c);
        logic [WW:0] cx;
        cx = '0;
        cx[0] = c;
        return {1'b0, x} + {1'b0, y} + cx;
    endfunction

    // Narrow scoreboard: model result queued at accept, compared while shown, popped when taken.
    logic [W:0] q16[$];
    logic       stall_prev = 1'b0;
    logic [W:0] held;
    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("stall_hold", {out_valid, cout, s}, {1'b1, held});
            if (out_valid) begin
                if (q16.size() == 0) chk("unexpected_out_valid", out_valid, 0);
                else begin
                    chk("sum_vs_model", {cout, s}, q16[0]);
                    if (out_ready) void'(q16.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {cout, s};
            if (in_valid && in_ready) q16.push_back(model16(a, b, cin, sub));
        end
    end

    typedef struct {
        logic [WW:0] v;
        int          t;
    } wexp_t;
    wexp_t qw[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        wexp_t       e;
        logic [WW:0] got;
        if (rst) qw.delete();
        else begin
            if (w_out_valid) begin
                if (qw.size() == 0) chk("wide_unexpected_out_valid", w_out_valid, 0);
                else begin
                    e   = qw[0];
                    got = {w_cout, w_s};
                    checks++;
                    if (got !== e.v) begin
                        failures++;
                        $display("FAIL wide_sum: got lo=0x%h cout=%b expected lo=0x%h cout=%b",
                                 got[63:0], got[WW], e.v[63:0], e.v[WW]);
                    end
                    chk("wide_latency", 64'(cyc - e.t), 64'd8);
                    if (w_out_ready) void'(qw.pop_front());
                end
            end
            if (w_in_valid && w_in_ready) begin
                e.v = model_w(w_a, w_b, w_cin);
                e.t = cyc;
                qw.push_back(e);
            end
        end
    end

    // Single op into an empty pipe with out_ready=1; result must appear after exactly 4 edges.
    task automatic lat_test(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input logic sb, input logic [W:0] lit, input string nm);
        a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk({nm, "_early"}, out_valid, 0);
            @(posedge clk); #1;
        end
        chk({nm, "_valid"}, out_valid, 1);
        chk(nm, {cout, s}, lit);
    endtask

    task automatic send16(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic sb, input bit rnd_rdy);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic rnd_wide(output logic [WW-1:0] v);
        for (int i = 0; i < WW / 32; i++) v[i*32 +: 32] = $urandom;
    endtask

    initial begin
        logic [WW:0]   pin;
        logic [WW-1:0] ones;
        int            n;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
        ones = '1;

        // Model pins against hand arithmetic
        chk("model_pin_add", model16(16'h1234, 16'h4321, 1'b1, 1'b0), 17'h05556);
        chk("model_pin_sub", model16(16'h0007, 16'h0005, 1'b0, 1'b1), SUB_EN ? 17'h10002 : 17'h0000C);
        pin = model_w(ones, '0, 1'b1);
        chk("wide_model_pin_cout", pin[WW], 1);
        chk("wide_model_pin_lo", pin[63:0], 64'd0);

        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wide_out_valid", w_out_valid, 0);
        chk("rst_wide_s_lo", w_s[63:0], 0);
        rst = 1'b0;
        @(posedge clk); #1;

        lat_test(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, "add_00ff_1");
        lat_test(16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, "wrap_ffff_cin");
        lat_test(16'h0FFF, 16'h0001, 1'b0, 1'b0, 17'h01000, "carry_3seg");
        lat_test(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, "top_carry");
        lat_test(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, "max_sum");
        lat_test(16'h0005, 16'h0007, 1'b0, 1'b1, SUB_EN ? 17'h0FFFE : 17'h0000C, "sub_5_7");
        lat_test(16'h0007, 16'h0005, 1'b0, 1'b1, SUB_EN ? 17'h10002 : 17'h0000C, "sub_7_5");

        // Back-to-back random ops with random consumer stalls
        for (int i = 0; i < 20; i++)
            send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b1);
        out_ready = 1'b1;
        n = 0;
        while (q16.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_narrow", q16.size(), 0);

        // Fill and stall the pipe, then reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 16'(i * 16'h1111); b = 16'h0F0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        chk("midrst_cout", cout, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_result", out_valid, 0);
        end

        // Wide default-config stream, consumer always ready
        w_in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (i == 0) begin
                w_a = ones; w_b = '0; w_cin = 1'b1;
            end else if (i == 1) begin
                w_a = ones; w_b = ones; w_cin = 1'b1;
            end else begin
                rnd_wide(w_a);
                rnd_wide(w_b);
                w_cin = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        n = 0;
        while (qw.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_wide", qw.size(), 0);
        chk("final_narrow_empty", q16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
